// File: rtl/uart_frame_rx.sv
// UART receiver feeding a SYNC/CMD/LEN/payload/CHK frame parser and a
// first-word-fall-through payload FIFO with sticky overflow reporting.
`timescale 1ns/1ps
module uart_frame_rx #(
    parameter int         CLK_DIV     = 434,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         MAX_LEN     = 512,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_BIT = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    output logic [7:0]                  cmd,
    output logic [15:0]                 frame_len,
    output logic                        frame_start,
    output logic                        frame_done,
    output logic                        frame_err,
    output logic [7:0]                  pld_data,
    output logic                        pld_valid,
    input  logic                        pld_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        clr_ovf
);
    localparam int              CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_DIV - 1);
    localparam int              TO_CYC    = TIMEOUT_BIT * CLK_DIV;
    localparam int              TW        = $clog2(TO_CYC);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TO_CYC - 1);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              LW        = AW + 1;
    localparam logic [LW-1:0]   FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [15:0]     MAX_LEN16 = 16'(MAX_LEN);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
    typedef enum logic [2:0] {P_HUNT, P_CMD, P_LENH, P_LENL, P_PLD, P_CHK} p_state_t;

    u_state_t        r_ustate;
    logic            r_rx_s1, r_rx_s2, r_rx_s3;
    logic [CW-1:0]   r_ucnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_byte_stb, r_ferr_stb;

    p_state_t        r_pstate;
    logic [7:0]      r_cmd, r_len_hi, r_acc, r_push_data;
    logic [15:0]     r_frame_len, r_pcnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_frame_start, r_frame_done, r_frame_err, r_push, r_frame_ovf;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_pld_data;
    logic            r_pld_valid, r_overflow;

    logic [15:0]     w_len;
    logic            w_pop, w_full, w_wr, w_drop;
    logic [AW-1:0]   w_rd_nxt;
    logic [LW-1:0]   w_lvl_nxt;

    // UART bit engine: mid-bit sampling off the synchronised line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_ustate   <= U_IDLE;
            r_ucnt     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_stb <= 1'b0;
            r_ferr_stb <= 1'b0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_byte_stb <= 1'b0;
            r_ferr_stb <= 1'b0;
            case (r_ustate)
                U_IDLE: begin
                    r_ucnt <= '0;
                    if (r_rx_s3 && !r_rx_s2) r_ustate <= U_START;
                end
                U_START: begin
                    if (r_ucnt == HALF_LAST) begin
                        r_ucnt    <= '0;
                        r_bit_idx <= '0;
                        r_ustate  <= r_rx_s2 ? U_IDLE : U_DATA;
                    end else begin
                        r_ucnt <= r_ucnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (r_ucnt == BIT_LAST) begin
                        r_ucnt    <= '0;
                        r_shift   <= {r_rx_s2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_ustate <= U_STOP;
                    end else begin
                        r_ucnt <= r_ucnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (r_ucnt == BIT_LAST) begin
                        r_ucnt     <= '0;
                        r_ustate   <= U_IDLE;
                        r_byte_stb <= r_rx_s2;
                        r_ferr_stb <= !r_rx_s2;
                    end else begin
                        r_ucnt <= r_ucnt + 1'b1;
                    end
                end
                default: r_ustate <= U_IDLE;
            endcase
        end
    end

    assign w_len = {r_len_hi, r_shift};

    // Frame parser: one step per received byte, plus inter-byte timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pstate      <= P_HUNT;
            r_cmd         <= '0;
            r_len_hi      <= '0;
            r_acc         <= '0;
            r_frame_len   <= '0;
            r_pcnt        <= '0;
            r_to_cnt      <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_push        <= 1'b0;
            r_push_data   <= '0;
            r_frame_ovf   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_push        <= 1'b0;
            r_to_cnt      <= (r_pstate == P_HUNT || r_byte_stb) ? '0 : r_to_cnt + 1'b1;
            if (r_byte_stb) begin
                case (r_pstate)
                    P_HUNT: if (r_shift == SYNC_BYTE) r_pstate <= P_CMD;
                    P_CMD: begin
                        r_cmd       <= r_shift;
                        r_acc       <= r_shift;
                        r_frame_ovf <= 1'b0;
                        r_pstate    <= P_LENH;
                    end
                    P_LENH: begin
                        r_len_hi <= r_shift;
                        r_acc    <= r_acc ^ r_shift;
                        r_pstate <= P_LENL;
                    end
                    P_LENL: begin
                        r_acc       <= r_acc ^ r_shift;
                        r_frame_len <= w_len;
                        r_pcnt      <= '0;
                        if (w_len > MAX_LEN16) begin
                            r_frame_err <= 1'b1;
                            r_pstate    <= P_HUNT;
                        end else begin
                            r_frame_start <= 1'b1;
                            r_pstate      <= (w_len == 16'd0) ? P_CHK : P_PLD;
                        end
                    end
                    P_PLD: begin
                        r_acc       <= r_acc ^ r_shift;
                        r_push      <= 1'b1;
                        r_push_data <= r_shift;
                        r_pcnt      <= r_pcnt + 16'd1;
                        if (r_pcnt + 16'd1 == r_frame_len) r_pstate <= P_CHK;
                    end
                    P_CHK: begin
                        if (r_shift == r_acc && !r_frame_ovf) r_frame_done <= 1'b1;
                        else                                  r_frame_err  <= 1'b1;
                        r_pstate <= P_HUNT;
                    end
                    default: r_pstate <= P_HUNT;
                endcase
            end else if (r_ferr_stb) begin
                if (r_pstate != P_HUNT) begin
                    r_frame_err <= 1'b1;
                    r_pstate    <= P_HUNT;
                end
            end else if (r_pstate != P_HUNT && r_to_cnt == TO_LAST) begin
                r_frame_err <= 1'b1;
                r_pstate    <= P_HUNT;
            end
            if (w_drop) r_frame_ovf <= 1'b1;
        end
    end

    assign w_pop     = r_pld_valid && pld_ready;
    assign w_full    = (r_level == FULL_LVL);
    assign w_wr      = r_push && (!w_full || w_pop);
    assign w_drop    = r_push && w_full && !w_pop;
    assign w_rd_nxt  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign w_lvl_nxt = r_level + LW'(w_wr) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
    end

    // FIFO control: head byte is re-registered so the consumer sees a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pld_data  <= '0;
            r_pld_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr    <= w_rd_nxt;
            r_level     <= w_lvl_nxt;
            r_pld_valid <= (w_lvl_nxt != '0);
            if (r_level == LW'(w_pop)) begin
                if (w_wr) r_pld_data <= r_push_data;
            end else begin
                r_pld_data <= r_mem[w_rd_nxt];
            end
            if (w_drop)       r_overflow <= 1'b1;
            else if (clr_ovf) r_overflow <= 1'b0;
        end
    end

    assign cmd         = r_cmd;
    assign frame_len   = r_frame_len;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign pld_data    = r_pld_data;
    assign pld_valid   = r_pld_valid;
    assign fifo_level  = r_level;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: serial frames are driven bit by bit and
// header, payload, status pulses and FIFO state are checked against hand values.
`timescale 1ns/1ps
module tb_uart_frame_rx;
    localparam int CLK_DIV     = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int MAX_LEN     = 8;
    localparam int TIMEOUT_BIT = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        pld_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [7:0]  cmd, pld_data;
    logic [15:0] frame_len;
    logic        frame_start, frame_done, frame_err, pld_valid, overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_last = 0;

    int n_start = 0, n_done = 0, n_err = 0, rx_wr = 0;
    logic [7:0]  st_cmd = 8'h00;
    logic [15:0] st_len = 16'h0000;
    logic [7:0]  rx_mem [256];

    uart_frame_rx #(
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(MAX_LEN),
        .SYNC_BYTE(8'hA5), .TIMEOUT_BIT(TIMEOUT_BIT)
    ) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .cmd(cmd), .frame_len(frame_len),
        .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
        .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus changes 2 ns after a rising edge, so the falling edge sees stable values
    always @(negedge clk) begin
        if (frame_start) begin
            n_start <= n_start + 1;
            st_cmd  <= cmd;
            st_len  <= frame_len;
        end
        if (frame_done) n_done <= n_done + 1;
        if (frame_err)  n_err  <= n_err + 1;
        if (pld_valid && pld_ready) begin
            rx_mem[rx_wr[7:0]] <= pld_data;
            rx_wr <= rx_wr + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input int pop_k, input int ncyc);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        t_last = cyc;
        for (int k = 0; k < ncyc; k++) begin
            rxd = fr[k / CLK_DIV];
            if (pop_k >= 0 && k == pop_k)          pld_ready = 1'b1;
            else if (pop_k >= 0 && k == pop_k + 1) pld_ready = 1'b0;
            @(posedge clk);
            #2;
        end
        rxd = 1'b1;
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b, 1'b1, -1, CLK_DIV * 10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        total++;
        if ({cmd, frame_len, pld_data} !== 32'd0) begin
            bad++; $display("FAIL reset_hdr_in_rst: got %h want 0", {cmd, frame_len, pld_data});
        end
        total++;
        if ({frame_start, frame_done, frame_err, pld_valid, overflow, fifo_level} !== 8'd0) begin
            bad++; $display("FAIL reset_flags_in_rst: got %b want 0",
                            {frame_start, frame_done, frame_err, pld_valid, overflow, fifo_level});
        end
        rst = 1'b0;
        tick(5);
        total++;
        if ({cmd, frame_len, pld_data, frame_start, frame_done, frame_err, pld_valid,
             overflow, fifo_level} !== 40'd0) begin
            bad++; $display("FAIL reset_after_release: outputs not all zero");
        end
    endtask

    task automatic test_good_frame();
        int s0, d0, e0, r0;
        logic [7:0] exp [2];
        exp[0] = 8'h11; exp[1] = 8'h22;
        s0 = n_start; d0 = n_done; e0 = n_err; r0 = rx_wr;
        pld_ready = 1'b1;
        // CHK = 03^00^02^11^22 = 32
        sb(8'hA5); sb(8'h03); sb(8'h00); sb(8'h02); sb(8'h11); sb(8'h22); sb(8'h32);
        tick(20);
        total++;
        if (n_start - s0 !== 1) begin bad++; $display("FAIL good_start_cnt: got %0d want 1", n_start - s0); end
        total++;
        if (st_cmd !== 8'h03) begin bad++; $display("FAIL good_cmd: got %h want 03", st_cmd); end
        total++;
        if (st_len !== 16'd2) begin bad++; $display("FAIL good_len: got %0d want 2", st_len); end
        total++;
        if (n_done - d0 !== 1) begin bad++; $display("FAIL good_done_cnt: got %0d want 1", n_done - d0); end
        total++;
        if (n_err - e0 !== 0) begin bad++; $display("FAIL good_err_cnt: got %0d want 0", n_err - e0); end
        total++;
        if (rx_wr - r0 !== 2) begin bad++; $display("FAIL good_pld_cnt: got %0d want 2", rx_wr - r0); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rx_mem[8'(r0 + i)] !== exp[i]) begin
                bad++; $display("FAIL good_pld_%0d: got %h want %h", i, rx_mem[8'(r0 + i)], exp[i]);
            end
        end
    endtask

    task automatic test_bad_chk();
        int s0, d0, e0, r0;
        s0 = n_start; d0 = n_done; e0 = n_err; r0 = rx_wr;
        pld_ready = 1'b1;
        sb(8'hA5); sb(8'h03); sb(8'h00); sb(8'h02); sb(8'h11); sb(8'h22); sb(8'h31);
        tick(20);
        total++;
        if (n_start - s0 !== 1) begin bad++; $display("FAIL badchk_start: got %0d want 1", n_start - s0); end
        total++;
        if (n_done - d0 !== 0) begin bad++; $display("FAIL badchk_done: got %0d want 0", n_done - d0); end
        total++;
        if (n_err - e0 !== 1) begin bad++; $display("FAIL badchk_err: got %0d want 1", n_err - e0); end
        total++;
        if (rx_wr - r0 !== 2 || rx_mem[8'(r0)] !== 8'h11 || rx_mem[8'(r0 + 1)] !== 8'h22) begin
            bad++; $display("FAIL badchk_pld: got n=%0d %h %h want n=2 11 22",
                            rx_wr - r0, rx_mem[8'(r0)], rx_mem[8'(r0 + 1)]);
        end
    endtask

    task automatic test_overflow();
        int s0, d0, e0, r0;
        s0 = n_start; d0 = n_done; e0 = n_err;
        pld_ready = 1'b0;
        sb(8'hA5); sb(8'h05); sb(8'h00); sb(8'h06);
        // Stop bit is sampled 155 clk after the start-bit drive; head valid 2 clk later
        send_byte(8'h01, 1'b1, -1, 156);
        total++;
        if (pld_valid !== 1'b0) begin bad++; $display("FAIL latency_early: pld_valid got %b want 0", pld_valid); end
        tick(1);
        total++;
        if (pld_valid !== 1'b1 || pld_data !== 8'h01) begin
            bad++; $display("FAIL latency_on_time: got valid=%b data=%h want 1 01", pld_valid, pld_data);
        end
        tick(3);
        sb(8'h02); sb(8'h03); sb(8'h04); sb(8'h05); sb(8'h06);
        // CHK = 05^00^06^01^02^03^04^05^06 = 04
        sb(8'h04);
        tick(20);
        total++;
        if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        total++;
        if (n_err - e0 !== 1 || n_done - d0 !== 0 || n_start - s0 !== 1) begin
            bad++; $display("FAIL ovf_pulses: got err=%0d done=%0d start=%0d want 1 0 1",
                            n_err - e0, n_done - d0, n_start - s0);
        end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        r0 = rx_wr;
        pld_ready = 1'b1;
        tick(10);
        total++;
        if (fifo_level !== 3'd0 || rx_wr - r0 !== 4) begin
            bad++; $display("FAIL ovf_drain: got level=%0d n=%0d want 0 4", fifo_level, rx_wr - r0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rx_mem[8'(r0 + i)] !== 8'(i + 1)) begin
                bad++; $display("FAIL ovf_pld_%0d: got %h want %h", i, rx_mem[8'(r0 + i)], 8'(i + 1));
            end
        end
    endtask

    task automatic test_hdr_errors();
        int s0, d0, e0, r0;
        pld_ready = 1'b1;
        s0 = n_start; e0 = n_err;
        sb(8'hA5); sb(8'h01); sb(8'h00); sb(8'h09);
        tick(20);
        total++;
        if (n_start - s0 !== 0 || n_err - e0 !== 1) begin
            bad++; $display("FAIL len_err: got start=%0d err=%0d want 0 1", n_start - s0, n_err - e0);
        end
        total++;
        if (cmd !== 8'h01 || frame_len !== 16'd9) begin
            bad++; $display("FAIL len_err_hdr: got cmd=%h len=%0d want 01 9", cmd, frame_len);
        end
        s0 = n_start; d0 = n_done; e0 = n_err; r0 = rx_wr;
        sb(8'hA5); sb(8'h02); sb(8'h00); sb(8'h03); sb(8'hAA);
        send_byte(8'hBB, 1'b0, -1, CLK_DIV * 10);
        tick(20);
        total++;
        if (n_start - s0 !== 1 || n_err - e0 !== 1 || n_done - d0 !== 0) begin
            bad++; $display("FAIL stop_err: got start=%0d err=%0d done=%0d want 1 1 0",
                            n_start - s0, n_err - e0, n_done - d0);
        end
        total++;
        if (rx_wr - r0 !== 1 || rx_mem[8'(r0)] !== 8'hAA) begin
            bad++; $display("FAIL stop_err_pld: got n=%0d %h want n=1 AA", rx_wr - r0, rx_mem[8'(r0)]);
        end
        s0 = n_start; d0 = n_done; e0 = n_err; r0 = rx_wr;
        // CHK = 04^00^01^5C = 59
        sb(8'h00); sb(8'hFF); sb(8'hA5); sb(8'h04); sb(8'h00); sb(8'h01); sb(8'h5C); sb(8'h59);
        tick(20);
        total++;
        if (n_start - s0 !== 1 || n_done - d0 !== 1 || n_err - e0 !== 0) begin
            bad++; $display("FAIL garbage: got start=%0d done=%0d err=%0d want 1 1 0",
                            n_start - s0, n_done - d0, n_err - e0);
        end
        total++;
        if (st_cmd !== 8'h04 || rx_wr - r0 !== 1 || rx_mem[8'(r0)] !== 8'h5C) begin
            bad++; $display("FAIL garbage_frame: got cmd=%h n=%0d pld=%h want 04 1 5C",
                            st_cmd, rx_wr - r0, rx_mem[8'(r0)]);
        end
    endtask

    task automatic test_timeout_glitch();
        int e0, s0, r0, dt;
        bit found;
        pld_ready = 1'b1;
        e0 = n_err;
        found = 1'b0;
        dt = -1;
        sb(8'hA5); sb(8'h01);
        for (int i = 0; i < 800 && !found; i++) begin
            @(negedge clk);
            if (frame_err) begin
                found = 1'b1;
                dt = cyc - t_last;
            end
        end
        // 156 clk from start-bit drive to byte strobe, then 32*16 = 512 idle clk
        total++;
        if (!found || dt !== 668) begin
            bad++; $display("FAIL timeout_time: got found=%0d dt=%0d want 1 668", found, dt);
        end
        tick(5);
        total++;
        if (n_err - e0 !== 1) begin bad++; $display("FAIL timeout_cnt: got %0d want 1", n_err - e0); end
        e0 = n_err; s0 = n_start; r0 = rx_wr;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(300);
        total++;
        if (n_err - e0 !== 0 || n_start - s0 !== 0 || rx_wr - r0 !== 0 || fifo_level !== 3'd0) begin
            bad++; $display("FAIL glitch: got err=%0d start=%0d bytes=%0d level=%0d want all 0",
                            n_err - e0, n_start - s0, rx_wr - r0, fifo_level);
        end
    endtask

    task automatic test_full_boundary();
        int d0, e0, r0;
        d0 = n_done; e0 = n_err; r0 = rx_wr;
        pld_ready = 1'b0;
        sb(8'hA5); sb(8'h06); sb(8'h00); sb(8'h05);
        sb(8'h01); sb(8'h02); sb(8'h03); sb(8'h04);
        // Consumer pops in exactly the cycle the fifth byte is written
        send_byte(8'h05, 1'b1, 156, CLK_DIV * 10);
        total++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            bad++; $display("FAIL full_pushpop: got level=%0d ovf=%b want 4 0", fifo_level, overflow);
        end
        // CHK = 06^00^05^01^02^03^04^05 = 02
        sb(8'h02);
        tick(20);
        total++;
        if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
            bad++; $display("FAIL full_frame: got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0);
        end
        pld_ready = 1'b1;
        tick(10);
        total++;
        if (rx_wr - r0 !== 5 || fifo_level !== 3'd0) begin
            bad++; $display("FAIL full_drain: got n=%0d level=%0d want 5 0", rx_wr - r0, fifo_level);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rx_mem[8'(r0 + i)] !== 8'(i + 1)) begin
                bad++; $display("FAIL full_pld_%0d: got %h want %h", i, rx_mem[8'(r0 + i)], 8'(i + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0, d0, e0, r0;
        pld_ready = 1'b1;
        sb(8'hA5); sb(8'h07); sb(8'h00); sb(8'h03); sb(8'hE1);
        send_byte(8'hE2, 1'b1, -1, 70);
        rst = 1'b1;
        #1;
        total++;
        if ({cmd, frame_len, pld_data, frame_start, frame_done, frame_err, pld_valid,
             overflow, fifo_level} !== 40'd0) begin
            bad++; $display("FAIL reset_mid: got cmd=%h len=%0d level=%0d valid=%b want all 0",
                            cmd, frame_len, fifo_level, pld_valid);
        end
        tick(3);
        rst = 1'b0;
        tick(200);
        s0 = n_start; d0 = n_done; e0 = n_err; r0 = rx_wr;
        // CHK = 08^00^01^77 = 7E
        sb(8'hA5); sb(8'h08); sb(8'h00); sb(8'h01); sb(8'h77); sb(8'h7E);
        tick(20);
        total++;
        if (n_start - s0 !== 1 || st_cmd !== 8'h08 || st_len !== 16'd1) begin
            bad++; $display("FAIL post_reset_hdr: got start=%0d cmd=%h len=%0d want 1 08 1",
                            n_start - s0, st_cmd, st_len);
        end
        total++;
        if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
            bad++; $display("FAIL post_reset_done: got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0);
        end
        total++;
        if (rx_wr - r0 !== 1 || rx_mem[8'(r0)] !== 8'h77) begin
            bad++; $display("FAIL post_reset_pld: got n=%0d %h want 1 77", rx_wr - r0, rx_mem[8'(r0)]);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_overflow();
        test_hdr_errors();
        test_timeout_glitch();
        test_full_boundary();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
